// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: single-outstanding instruction fetch sequencer with
// next-PC selection, imem ack timeout and sticky fault reporting.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_inst;
  logic [31:0]   r_retired;
  logic          r_fault;
  logic [1:0]    r_code;
  logic [WW-1:0] r_wait;

  logic [31:0]   w_next_pc;
  logic          w_misalign;

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    unique case (1'b1)
      (pc_src == 2'b01): w_next_pc = r_pc + imm;
      (pc_src == 2'b10): w_next_pc = alu_out & 32'hFFFF_FFFE;
      default: ;
    endcase
  end

  assign w_misalign = |w_next_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_retired <= '0;
      r_fault   <= 1'b0;
      r_code    <= 2'b00;
      r_wait    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (run_en) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_inst  <= imem_rdata;
            r_state <= S_ISSUE;
          end else if (r_wait == WAIT_LAST) begin
            r_state <= S_HALT;
            if (!r_fault) begin
              r_fault <= 1'b1;
              r_code  <= FC_TIMEOUT;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_ISSUE: begin
          if (inst_ready) begin
            r_retired <= r_retired + 32'd1;
            // a misaligned target still retires the offered instruction
            if (w_misalign) begin
              r_state <= S_HALT;
              if (!r_fault) begin
                r_fault <= 1'b1;
                r_code  <= FC_MISALIGN;
              end
            end else begin
              r_pc    <= w_next_pc;
              r_wait  <= '0;
              r_state <= run_en ? S_FETCH : S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == S_ISSUE);
  assign inst       = r_inst;
  assign pc         = r_pc;
  assign pc_plus4   = r_pc + 32'd4;
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign retired    = r_retired;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table, corner sequences and
// randomized transactions against a transaction-level PC model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm = '0;
  logic [31:0] alu_out = '0;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .pc_src     (pc_src),
    .imm        (imm),
    .alu_out    (alu_out),
    .fault      (fault),
    .fault_code (fault_code),
    .retired    (retired)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    int          ack_dly;
    int          rdy_dly;
    logic [31:0] exp_next;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_pc4"}, pc_plus4, RST_PC + 32'd4);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
    chk({tag, "_code"}, {30'b0, fault_code}, 32'd0);
    chk({tag, "_ret"}, retired, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_en = 1'b0;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    pc_src = 2'b00;
    imm = '0;
    alu_out = '0;
    imem_rdata = '0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  task automatic start();
    run_en = 1'b1;
    tick();
    chk("start_req", {31'b0, imem_req}, 32'd1);
    chk("start_addr", imem_addr, RST_PC);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int dly,
                          input logic [31:0] d);
    chk("f_req", {31'b0, imem_req}, 32'd1);
    chk("f_addr", imem_addr, a);
    repeat (dly) begin
      tick();
      chk("f_req_hold", {31'b0, imem_req}, 32'd1);
      chk("f_addr_hold", imem_addr, a);
      chk("f_valid_lo", {31'b0, inst_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = d;
    tick();
    imem_ack = 1'b0;
    imem_rdata = ~d;
    chk("i_valid", {31'b0, inst_valid}, 32'd1);
    chk("i_inst", inst, d);
    chk("i_pc", pc, a);
    chk("i_pc4", pc_plus4, a + 32'd4);
    chk("i_req_lo", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic do_issue(input int dly, input logic [1:0] s,
                          input logic [31:0] im, input logic [31:0] al,
                          input logic [31:0] hi, input logic [31:0] hp);
    repeat (dly) begin
      imem_ack = 1'b1;
      imem_rdata = ~hi;
      tick();
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_inst", inst, hi);
      chk("bp_pc", pc, hp);
      chk("bp_req_lo", {31'b0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    pc_src = s;
    imm = im;
    alu_out = al;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p,
      input logic [1:0] s, input logic [31:0] im, input logic [31:0] al);
    if (s == 2'b01) return p + im;
    if (s == 2'b10) return {al[31:1], 1'b0};
    return p + 32'd4;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] d;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] nxt;
    logic [31:0] im;
    logic [31:0] al;
    logic [1:0]  s;
    logic        stop;

    tbl[0] = '{2'b00, 32'h0, 32'h0, 2, 0, 32'h0000_0004};
    tbl[1] = '{2'b00, 32'h0, 32'h0, 2, 0, 32'h0000_0008};
    tbl[2] = '{2'b01, 32'hFFFF_FFF8, 32'h0, 2, 0, 32'h0000_0000};
    tbl[3] = '{2'b10, 32'h0, 32'h0000_0101, 1, 5, 32'h0000_0100};
    tbl[4] = '{2'b11, 32'h0, 32'h0, 0, 0, 32'h0000_0104};
    tbl[5] = '{2'b10, 32'h0, 32'hFFFF_FFFD, 3, 1, 32'hFFFF_FFFC};
    tbl[6] = '{2'b00, 32'h0, 32'h0, 0, 2, 32'h0000_0000};
    tbl[7] = '{2'b01, 32'h0000_0040, 32'h0, 1, 0, 32'h0000_0040};

    #2;
    chk_reset_vals("por");
    do_reset();
    start();

    exp_pc = RST_PC;
    for (int i = 0; i < 8; i++) begin
      d = 32'h0000_0013 | (i << 20);
      do_fetch(exp_pc, tbl[i].ack_dly, d);
      do_issue(tbl[i].rdy_dly, tbl[i].src, tbl[i].imm, tbl[i].alu,
               d, exp_pc);
      chk("v_req", {31'b0, imem_req}, 32'd1);
      chk("v_next", imem_addr, tbl[i].exp_next);
      chk("v_ret", retired, i + 1);
      chk("v_fault", {31'b0, fault}, 32'd0);
      exp_pc = tbl[i].exp_next;
    end

    do_fetch(32'h0000_0040, 0, 32'hCAFE_0013);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, RST_PC);

    run_en = 1'b0;
    tick();
    chk("noabort_req", {31'b0, imem_req}, 32'd1);
    do_fetch(RST_PC, 1, 32'h1234_5678);
    do_issue(1, 2'b00, 32'h0, 32'h0, 32'h1234_5678, RST_PC);
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    chk("idle_valid", {31'b0, inst_valid}, 32'd0);
    chk("idle_pc", pc, RST_PC + 32'd4);
    chk("idle_ret", retired, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b1;
    tick();
    tick();
    chk("ign_ret", retired, 32'd1);
    chk("ign_inst", inst, 32'h1234_5678);
    chk("ign_req", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    run_en = 1'b1;
    tick();
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, RST_PC + 32'd4);

    do_reset();
    start();
    do_fetch(RST_PC, 0, 32'h0000_0013);
    do_issue(0, 2'b01, 32'h0000_0006, 32'h0, 32'h0000_0013, RST_PC);
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_code", {30'b0, fault_code}, 32'd1);
    chk("mis_ret", retired, 32'd1);
    chk("mis_pc", pc, RST_PC);
    chk("mis_valid", {31'b0, inst_valid}, 32'd0);
    imem_ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      inst_ready = k[0];
      tick();
      chk("halt_req", {31'b0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    chk("halt_code", {30'b0, fault_code}, 32'd1);
    chk("halt_ret", retired, 32'd1);

    do_reset();
    start();
    for (int k = 0; k < MW - 1; k++) begin
      tick();
      chk("to_req_hold", {31'b0, imem_req}, 32'd1);
      chk("to_fault_lo", {31'b0, fault}, 32'd0);
    end
    tick();
    chk("to_req", {31'b0, imem_req}, 32'd0);
    chk("to_fault", {31'b0, fault}, 32'd1);
    chk("to_code", {30'b0, fault_code}, 32'd2);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_ign_inst", inst, 32'd0);
      chk("to_ign_valid", {31'b0, inst_valid}, 32'd0);
      chk("to_ign_code", {30'b0, fault_code}, 32'd2);
    end
    imem_ack = 1'b0;

    do_reset();
    start();
    m_pc = RST_PC;
    m_ret = '0;
    for (int t = 0; t < 300; t++) begin
      d = $urandom();
      do_fetch(m_pc, $urandom_range(0, 3), d);
      s = 2'($urandom_range(0, 3));
      im = $urandom() & 32'hFFFF_FFFC;
      al = $urandom() & 32'hFFFF_FFFD;
      if ($urandom_range(0, 15) == 0) begin
        im = im | $urandom_range(1, 3);
        al = al | 32'h2;
      end
      stop = ($urandom_range(0, 7) == 0);
      if (stop) run_en = 1'b0;
      do_issue($urandom_range(0, 3), s, im, al, d, m_pc);
      nxt = model_next(m_pc, s, im, al);
      m_ret = m_ret + 32'd1;
      chk("r_ret", retired, m_ret);
      if (nxt[1:0] != 2'b00) begin
        chk("r_fault", {31'b0, fault}, 32'd1);
        chk("r_code", {30'b0, fault_code}, 32'd1);
        chk("r_pc_keep", pc, m_pc);
        chk("r_req_lo", {31'b0, imem_req}, 32'd0);
        do_reset();
        start();
        m_pc = RST_PC;
        m_ret = '0;
      end else begin
        m_pc = nxt;
        chk("r_fault_lo", {31'b0, fault}, 32'd0);
        chk("r_pc", pc, m_pc);
        if (stop) begin
          chk("r_idle_req", {31'b0, imem_req}, 32'd0);
          repeat ($urandom_range(0, 3)) tick();
          run_en = 1'b1;
          tick();
        end
        chk("r_req", {31'b0, imem_req}, 32'd1);
        chk("r_addr", imem_addr, m_pc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
